// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the three handshakes around the load/store unit:
//   req_*  : EX stage -> unit (one operation, valid/ready)
//   rsp_*  : unit -> WB stage (result, valid/ready)
//   data_* : unit <-> data SRAM bus (request/addr_ok/data_ok)
// Modports:
//   slave  : the load/store unit itself (serves EX, masters the SRAM bus)
//   master : the environment (EX/WB stages and the SRAM bus model)
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_sign;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  flush;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic [1:0]            rsp_ex;
   logic [ADDR_W-1:0]     rsp_badvaddr;
   logic                  data_req;
   logic                  data_wr;
   logic [DATA_W/8-1:0]   data_wstrb;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W-1:0]     data_wdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;
   logic [DATA_W-1:0]     data_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, flush,
      input  rsp_ready, data_addr_ok, data_data_ok, data_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_ex, rsp_badvaddr,
      output data_req, data_wr, data_wstrb, data_addr, data_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, flush,
      output rsp_ready, data_addr_ok, data_data_ok, data_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_ex, rsp_badvaddr,
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between EX and the data SRAM bus. Takes one operation at a
// time, checks alignment, drives byte strobes and lane-shifted store data,
// waits on the addr_ok/data_ok bus, and returns extended load data.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_access_unit_if.slave (req_*, rsp_*, flush, data_*)
// Parameters: DATA_W (32 or 64), ADDR_W.
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   mem_access_unit_if.slave bus
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t               state, state_nxt;
   logic                 killed, killed_nxt;
   logic                 accept, capture;
   logic                 req_mis;

   // Operation fields, loaded on acceptance only; outputs are gated by state
   // so these need no reset.
   logic                 we_q, sign_q;
   logic [1:0]           size_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [NB-1:0]        wstrb_q;
   logic [DATA_W-1:0]    wdata_q, rdata_q;
   logic [1:0]           ex_q;
   logic [OFF_W-1:0]     req_off;

   assign req_off = bus.req_addr[OFF_W-1:0];

   function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
      int n;
      n = 1 << size;
      if (size == 2'd3 && DATA_W == 32) return 1'b1;
      return (int'(off) & (n - 1)) != 0;
   endfunction

   function automatic logic [NB-1:0] lane_strb(input logic [1:0] size, input logic [OFF_W-1:0] off);
      int n;
      n = 1 << size;
      return NB'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [DATA_W-1:0] lane_wdata(input logic [DATA_W-1:0] wdata,
                                                    input logic [1:0] size,
                                                    input logic [OFF_W-1:0] off);
      int n;
      logic [DATA_W-1:0] bmask;
      n = 1 << size;
      if (n >= NB) bmask = '1;
      else         bmask = (DATA_W'(1) << (8 * n)) - DATA_W'(1);
      return (wdata & bmask) << (8 * off);
   endfunction

   function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata,
                                                  input logic [1:0] size,
                                                  input logic sign,
                                                  input logic [OFF_W-1:0] off);
      int nbits;
      logic [DATA_W-1:0] sh, mask, top;
      nbits = 8 << size;
      sh    = rdata >> (8 * off);
      // Full-width loads have nothing to extend.
      if (nbits >= DATA_W) return sh;
      mask = (DATA_W'(1) << nbits) - DATA_W'(1);
      top  = sh >> (nbits - 1);
      if (sign && top[0]) return sh | ~mask;
      return sh & mask;
   endfunction

   assign req_mis = misaligned(bus.req_size, req_off);

   always_comb begin
      state_nxt     = state;
      killed_nxt    = killed;
      accept        = 1'b0;
      capture       = 1'b0;
      bus.req_ready = 1'b0;
      bus.data_req  = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            killed_nxt    = 1'b0;
            bus.req_ready = !bus.flush;
            if (bus.req_valid && !bus.flush) begin
               accept    = 1'b1;
               state_nxt = req_mis ? RESP : REQ;
            end
         end
         REQ: begin
            // The request cannot be withdrawn once raised; a flush only marks it.
            bus.data_req = 1'b1;
            if (bus.flush) killed_nxt = 1'b1;
            if (bus.data_addr_ok) begin
               if (bus.data_data_ok) begin
                  if (killed || bus.flush) state_nxt = IDLE;
                  else begin
                     capture   = 1'b1;
                     state_nxt = RESP;
                  end
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.flush) killed_nxt = 1'b1;
            if (bus.data_data_ok) begin
               if (killed || bus.flush) state_nxt = IDLE;
               else begin
                  capture   = 1'b1;
                  state_nxt = RESP;
               end
            end
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.flush || bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         killed <= 1'b0;
      end else begin
         state  <= state_nxt;
         killed <= killed_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         sign_q  <= bus.req_sign;
         size_q  <= bus.req_size;
         addr_q  <= bus.req_addr;
         wstrb_q <= lane_strb(bus.req_size, req_off);
         wdata_q <= lane_wdata(bus.req_wdata, bus.req_size, req_off);
         rdata_q <= '0;
         if (req_mis) ex_q <= bus.req_we ? 2'b10 : 2'b01;
         else         ex_q <= 2'b00;
      end else if (capture) begin
         rdata_q <= we_q ? '0 : load_ext(bus.data_rdata, size_q, sign_q, addr_q[OFF_W-1:0]);
      end
   end

   assign bus.data_wr      = bus.data_req && we_q;
   assign bus.data_wstrb   = (bus.data_req && we_q) ? wstrb_q : '0;
   assign bus.data_wdata   = (bus.data_req && we_q) ? wdata_q : '0;
   assign bus.data_addr    = bus.data_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign bus.rsp_rdata    = (state == RESP) ? rdata_q : '0;
   assign bus.rsp_ex       = (state == RESP) ? ex_q : 2'b00;
   assign bus.rsp_badvaddr = (state == RESP && ex_q != 2'b00) ? addr_q : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) a ();
   mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) b ();

   mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (.clk(clk), .reset(reset), .bus(a.slave));
   mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (.clk(clk), .reset(reset), .bus(b.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operation to the 32-bit unit for a single cycle.
   task automatic a_op(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
      a.req_valid = 1'b1; a.req_we = we; a.req_size = sz; a.req_sign = sg;
      a.req_addr = ad; a.req_wdata = wd;
      step();
      a.req_valid = 1'b0;
   endtask

   task automatic b_op(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [63:0] wd);
      b.req_valid = 1'b1; b.req_we = we; b.req_size = sz; b.req_sign = sg;
      b.req_addr = ad; b.req_wdata = wd;
      step();
      b.req_valid = 1'b0;
   endtask

   task automatic a_consume();
      a.rsp_ready = 1'b1;
      step();
      a.rsp_ready = 1'b0;
   endtask

   task automatic b_consume();
      b.rsp_ready = 1'b1;
      step();
      b.rsp_ready = 1'b0;
   endtask

   initial begin
      a.req_valid = 0; a.req_we = 0; a.req_size = 0; a.req_sign = 0; a.req_addr = 0;
      a.req_wdata = 0; a.flush = 0; a.rsp_ready = 0; a.data_addr_ok = 0;
      a.data_data_ok = 0; a.data_rdata = 0;
      b.req_valid = 0; b.req_we = 0; b.req_size = 0; b.req_sign = 0; b.req_addr = 0;
      b.req_wdata = 0; b.flush = 0; b.rsp_ready = 0; b.data_addr_ok = 0;
      b.data_data_ok = 0; b.data_rdata = 0;
      reset = 1'b1;
      step();
      step();

      // Reset state
      chk("rst req_ready", a.req_ready, 1);
      chk("rst data_req", a.data_req, 0);
      chk("rst rsp_valid", a.rsp_valid, 0);
      chk("rst data_addr", a.data_addr, 0);
      chk("rst rsp_ex", a.rsp_ex, 0);
      chk("rst64 req_ready", b.req_ready, 1);
      reset = 1'b0;
      step();

      // Signed byte load at 0x1003, immediate bus
      a_op(0, 2'd0, 1, 32'h1003, 0);
      chk("lb data_req c1", a.data_req, 1);
      chk("lb data_addr", a.data_addr, 32'h1000);
      chk("lb wstrb", a.data_wstrb, 0);
      chk("lb data_wr", a.data_wr, 0);
      chk("lb rsp_valid c1", a.rsp_valid, 0);
      a.data_addr_ok = 1; a.data_data_ok = 1; a.data_rdata = 32'h80AA5511;
      step();
      a.data_addr_ok = 0; a.data_data_ok = 0;
      chk("lb rsp_valid c2", a.rsp_valid, 1);
      chk("lb rsp_rdata", a.rsp_rdata, 32'hFFFFFF80);
      chk("lb rsp_ex", a.rsp_ex, 0);
      chk("lb data_req c2", a.data_req, 0);
      a_consume();
      chk("lb req_ready after", a.req_ready, 1);
      chk("lb rsp_valid after", a.rsp_valid, 0);

      // Half store at 0x2002 with addr_ok stalled three cycles
      a_op(1, 2'd1, 0, 32'h2002, 32'h0000BEEF);
      for (int c = 0; c < 4; c++) begin
         chk("sh data_req", a.data_req, 1);
         chk("sh data_wr", a.data_wr, 1);
         chk("sh wstrb", a.data_wstrb, 4'b1100);
         chk("sh wdata", a.data_wdata, 32'hBEEF0000);
         chk("sh addr", a.data_addr, 32'h2000);
         if (c == 3) a.data_addr_ok = 1;
         step();
         a.data_addr_ok = 0;
      end
      chk("sh wait data_req", a.data_req, 0);
      chk("sh wait rsp_valid", a.rsp_valid, 0);
      step();
      a.data_data_ok = 1; a.data_rdata = 32'h55555555;
      step();
      a.data_data_ok = 0;
      chk("sh rsp_valid", a.rsp_valid, 1);
      chk("sh rsp_rdata", a.rsp_rdata, 0);
      chk("sh rsp_ex", a.rsp_ex, 0);
      a_consume();

      // Misaligned word load / store and dword on a 32-bit path
      a_op(0, 2'd2, 0, 32'h3002, 0);
      chk("adel data_req", a.data_req, 0);
      chk("adel rsp_valid", a.rsp_valid, 1);
      chk("adel rsp_ex", a.rsp_ex, 2'b01);
      chk("adel badvaddr", a.rsp_badvaddr, 32'h3002);
      chk("adel rdata", a.rsp_rdata, 0);
      a_consume();
      a_op(1, 2'd2, 0, 32'h3002, 32'h12345678);
      chk("ades data_req", a.data_req, 0);
      chk("ades rsp_ex", a.rsp_ex, 2'b10);
      chk("ades badvaddr", a.rsp_badvaddr, 32'h3002);
      a_consume();
      a_op(0, 2'd3, 0, 32'h4000, 0);
      chk("dw32 rsp_ex", a.rsp_ex, 2'b01);
      chk("dw32 badvaddr", a.rsp_badvaddr, 32'h4000);
      chk("dw32 data_req", a.data_req, 0);
      a_consume();

      // 64-bit path
      b_op(0, 2'd2, 0, 32'h104, 0);
      chk("lw64 data_addr", b.data_addr, 32'h100);
      b.data_addr_ok = 1; b.data_data_ok = 1; b.data_rdata = 64'h8765432100000000;
      step();
      b.data_addr_ok = 0; b.data_data_ok = 0;
      chk("lwu64 rdata", b.rsp_rdata, 64'h0000000087654321);
      b_consume();
      b_op(0, 2'd2, 1, 32'h104, 0);
      b.data_addr_ok = 1; b.data_data_ok = 1; b.data_rdata = 64'h8765432100000000;
      step();
      b.data_addr_ok = 0; b.data_data_ok = 0;
      chk("lw64 signed rdata", b.rsp_rdata, 64'hFFFFFFFF87654321);
      b_consume();
      b_op(1, 2'd3, 0, 32'h108, 64'h1122334455667788);
      chk("sd64 wstrb", b.data_wstrb, 8'hFF);
      chk("sd64 wdata", b.data_wdata, 64'h1122334455667788);
      chk("sd64 addr", b.data_addr, 32'h108);
      b.data_addr_ok = 1; b.data_data_ok = 1;
      step();
      b.data_addr_ok = 0; b.data_data_ok = 0;
      chk("sd64 rsp_valid", b.rsp_valid, 1);
      chk("sd64 rdata", b.rsp_rdata, 0);
      b_consume();

      // Flush in REQ during an addr_ok stall
      a_op(0, 2'd2, 0, 32'h5000, 0);
      chk("flreq data_req c1", a.data_req, 1);
      a.flush = 1;
      step();
      a.flush = 0;
      chk("flreq data_req held", a.data_req, 1);
      chk("flreq req_ready", a.req_ready, 0);
      a.data_addr_ok = 1;
      step();
      a.data_addr_ok = 0;
      chk("flreq wait data_req", a.data_req, 0);
      a.data_data_ok = 1; a.data_rdata = 32'hDEADBEEF;
      step();
      a.data_data_ok = 0;
      chk("flreq rsp_valid", a.rsp_valid, 0);
      chk("flreq req_ready", a.req_ready, 1);
      step();
      chk("flreq rsp_valid later", a.rsp_valid, 0);

      // Flush in IDLE blocks acceptance
      a.req_valid = 1; a.req_we = 0; a.req_size = 2'd1; a.req_addr = 32'h5001; a.flush = 1;
      #1;
      chk("flidle req_ready", a.req_ready, 0);
      step();
      a.req_valid = 0; a.flush = 0;
      #1;
      chk("flidle rsp_valid", a.rsp_valid, 0);
      chk("flidle data_req", a.data_req, 0);
      chk("flidle req_ready", a.req_ready, 1);

      // Flush in RESP drops the response
      a_op(1, 2'd1, 0, 32'h5001, 0);
      chk("flresp rsp_valid", a.rsp_valid, 1);
      chk("flresp rsp_ex", a.rsp_ex, 2'b10);
      a.flush = 1;
      step();
      a.flush = 0;
      #1;
      chk("flresp dropped", a.rsp_valid, 0);
      chk("flresp req_ready", a.req_ready, 1);
      chk("flresp rsp_ex", a.rsp_ex, 0);

      // Reset while in WAIT, then a stray data_ok
      a_op(0, 2'd2, 0, 32'h6000, 0);
      a.data_addr_ok = 1;
      step();
      a.data_addr_ok = 0;
      chk("rstw wait data_req", a.data_req, 0);
      reset = 1;
      step();
      reset = 0;
      chk("rstw req_ready", a.req_ready, 1);
      chk("rstw data_req", a.data_req, 0);
      chk("rstw data_addr", a.data_addr, 0);
      a.data_data_ok = 1; a.data_rdata = 32'h11111111;
      step();
      a.data_data_ok = 0;
      chk("rstw stray rsp_valid", a.rsp_valid, 0);
      chk("rstw stray rsp_rdata", a.rsp_rdata, 0);
      chk("rstw stray req_ready", a.req_ready, 1);
      a_op(0, 2'd1, 0, 32'h6002, 0);
      a.data_addr_ok = 1; a.data_data_ok = 1; a.data_rdata = 32'hCAFE1234;
      step();
      a.data_addr_ok = 0; a.data_data_ok = 0;
      chk("rstw next rsp_valid", a.rsp_valid, 1);
      chk("rstw next lhu", a.rsp_rdata, 32'h0000CAFE);
      a_consume();
      chk("rstw next req_ready", a.req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
